// File: rtl/arb_types.sv
// Shared types for the memory port arbiter.
package arb_types;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Requester identity, used to remember who was granted last.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

  // On a tie, the requester that was not granted last wins.
  function automatic arb_req_t tie_winner(input arb_req_t last);
    return (last == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the single physical memory port.
module mem_port_arbiter
  import arb_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch port
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic                i_resp,
  output logic [DATA_W-1:0]   i_rdata,
  // load/store port
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_enable,
  output logic                d_resp,
  output logic [DATA_W-1:0]   d_rdata,
  // downstream memory port
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_byte_enable,
  input  logic                pmem_resp,
  input  logic [DATA_W-1:0]   pmem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;

  arb_state_t state, next_state;
  arb_req_t   last_grant, next_last_grant;
  logic       grant_i, grant_d;
  logic       d_any;

  assign d_any = d_read | d_write;

  // FSM and round-robin bookkeeping register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_I;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  // Next-state and grant decision; requests are only sampled in IDLE.
  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    grant_i         = 1'b0;
    grant_d         = 1'b0;
    case (state)
      IDLE: begin
        if (i_read && d_any) begin
          if (tie_winner(last_grant) == REQ_D) grant_d = 1'b1;
          else                                 grant_i = 1'b1;
        end else if (d_any) begin
          grant_d = 1'b1;
        end else if (i_read) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          next_state      = SERVE_D;
          next_last_grant = REQ_D;
        end else if (grant_i) begin
          next_state      = SERVE_I;
          next_last_grant = REQ_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Downstream request register: loaded on grant, strobes cleared on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
    end else if (grant_i) begin
      pmem_read        <= 1'b1;
      pmem_write       <= 1'b0;
      pmem_address     <= i_address;
      pmem_wdata       <= '0;
      pmem_byte_enable <= MASK_W'(0);
    end else if (grant_d) begin
      // a simultaneous read+write request is carried out as a write only
      pmem_read        <= d_read & ~d_write;
      pmem_write       <= d_write;
      pmem_address     <= d_address;
      pmem_wdata       <= d_wdata;
      pmem_byte_enable <= d_byte_enable;
    end else if (pmem_resp && (state != IDLE)) begin
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
    end
  end

  // Completion is steered to the owner in the same cycle; stale responses in IDLE are dropped.
  assign i_resp  = (state == SERVE_I) & pmem_resp;
  assign d_resp  = (state == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic        i_resp;
  logic [31:0] i_rdata;
  logic        d_read, d_write;
  logic [31:0] d_address, d_wdata;
  logic [3:0]  d_byte_enable;
  logic        d_resp;
  logic [31:0] d_rdata;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; d_byte_enable = '0; pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
    checks++; if (pmem_address !== 32'h0) begin errors++; $display("FAIL reset_pmem_address: got %h want 0", pmem_address); end
    checks++; if (pmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_pmem_wdata: got %h want 0", pmem_wdata); end
    checks++; if (pmem_byte_enable !== 4'h0) begin errors++; $display("FAIL reset_pmem_be: got %h want 0", pmem_byte_enable); end
    checks++; if ({i_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b want 00", {i_resp, d_resp}); end
    rst = 1'b0;
  endtask

  // Fetch of 0x60, memory answers in the third strobe cycle.
  task automatic test_single_i();
    int strobe_cycles = 0;
    @(negedge clk);
    i_read = 1'b1; i_address = 32'h60;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin pmem_resp = 1'b1; pmem_rdata = 32'h0000_0013; end
      #1;
      if (pmem_read === 1'b1) strobe_cycles++;
      checks++; if (pmem_address !== 32'h60) begin errors++; $display("FAIL single_i_addr: got %h want 00000060", pmem_address); end
      checks++; if (i_resp !== (c == 2)) begin errors++; $display("FAIL single_i_resp c%0d: got %b want %b", c, i_resp, (c == 2)); end
      checks++; if (d_resp !== 1'b0) begin errors++; $display("FAIL single_i_dresp c%0d: got %b want 0", c, d_resp); end
    end
    checks++; if (i_rdata !== 32'h0000_0013) begin errors++; $display("FAIL single_i_rdata: got %h want 00000013", i_rdata); end
    @(negedge clk);
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    if (pmem_read === 1'b1) strobe_cycles++;
    checks++; if (strobe_cycles != 3) begin errors++; $display("FAIL single_i_strobe_len: got %0d want 3", strobe_cycles); end
    checks++; if (i_resp !== 1'b0) begin errors++; $display("FAIL single_i_resp_after: got %b want 0", i_resp); end
  endtask

  // Tie right after reset: D (0x100) first, then I (0x64).
  task automatic test_tie_after_reset();
    apply_reset();
    i_read = 1'b1; i_address = 32'h64; d_read = 1'b1; d_address = 32'h100;
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = 32'hAAAA_5555;
    #1;
    checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h100}) begin errors++; $display("FAIL tie_first: got rd=%b addr=%h want rd=1 addr=00000100", pmem_read, pmem_address); end
    checks++; if ({d_resp, i_resp} !== 2'b10) begin errors++; $display("FAIL tie_first_resp: got d/i=%b want 10", {d_resp, i_resp}); end
    checks++; if (d_rdata !== 32'hAAAA_5555) begin errors++; $display("FAIL tie_d_rdata: got %h want aaaa5555", d_rdata); end
    @(negedge clk);
    pmem_resp = 1'b0; d_read = 1'b0;
    #1;
    checks++; if ({pmem_read, d_resp, i_resp} !== 3'b000) begin errors++; $display("FAIL tie_idle_gap: got rd/d/i=%b want 000", {pmem_read, d_resp, i_resp}); end
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = 32'h1234_0000;
    #1;
    checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h64}) begin errors++; $display("FAIL tie_second: got rd=%b addr=%h want rd=1 addr=00000064", pmem_read, pmem_address); end
    checks++; if ({d_resp, i_resp} !== 2'b01) begin errors++; $display("FAIL tie_second_resp: got d/i=%b want 01", {d_resp, i_resp}); end
    @(negedge clk);
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    checks++; if ({pmem_read, d_resp, i_resp} !== 3'b000) begin errors++; $display("FAIL tie_done: got rd/d/i=%b want 000", {pmem_read, d_resp, i_resp}); end
  endtask

  // Masked data write, one wait cycle before completion.
  task automatic test_write();
    @(negedge clk);
    d_write = 1'b1; d_address = 32'h200; d_wdata = 32'hDEAD_BEEF; d_byte_enable = 4'b0011;
    @(negedge clk);
    #1;
    checks++; if ({pmem_write, pmem_read} !== 2'b10) begin errors++; $display("FAIL write_strobes: got w/r=%b want 10", {pmem_write, pmem_read}); end
    checks++; if (pmem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_wdata: got %h want deadbeef", pmem_wdata); end
    checks++; if (pmem_byte_enable !== 4'b0011) begin errors++; $display("FAIL write_be: got %b want 0011", pmem_byte_enable); end
    checks++; if (pmem_address !== 32'h200) begin errors++; $display("FAIL write_addr: got %h want 00000200", pmem_address); end
    checks++; if (d_resp !== 1'b0) begin errors++; $display("FAIL write_early_resp: got %b want 0", d_resp); end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++; if ({d_resp, i_resp} !== 2'b10) begin errors++; $display("FAIL write_resp: got d/i=%b want 10", {d_resp, i_resp}); end
    @(negedge clk);
    pmem_resp = 1'b0; d_write = 1'b0; d_byte_enable = 4'b0000;
    #1;
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL write_clear: got %b want 0", pmem_write); end
  endtask

  // Both requesters held, zero-wait memory: D,I,D,I,D,I with an IDLE gap each.
  task automatic test_alternate();
    apply_reset();
    i_read = 1'b1; i_address = 32'h64; d_read = 1'b1; d_address = 32'h100;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      pmem_resp = pmem_read;
      if (t == 11) begin i_read = 1'b0; d_read = 1'b0; end
      #1;
      if (t % 2 == 0) begin
        if ((t / 2) % 2 == 0) begin
          checks++; if ({pmem_read, pmem_address, d_resp, i_resp} !== {1'b1, 32'h100, 2'b10}) begin errors++; $display("FAIL alt_d t%0d: got rd=%b addr=%h d/i=%b want rd=1 addr=00000100 d/i=10", t, pmem_read, pmem_address, {d_resp, i_resp}); end
        end else begin
          checks++; if ({pmem_read, pmem_address, d_resp, i_resp} !== {1'b1, 32'h64, 2'b01}) begin errors++; $display("FAIL alt_i t%0d: got rd=%b addr=%h d/i=%b want rd=1 addr=00000064 d/i=01", t, pmem_read, pmem_address, {d_resp, i_resp}); end
        end
      end else begin
        checks++; if ({pmem_read, d_resp, i_resp} !== 3'b000) begin errors++; $display("FAIL alt_idle t%0d: got rd/d/i=%b want 000", t, {pmem_read, d_resp, i_resp}); end
      end
    end
  endtask

  // Reset while serving D, then a stale pmem_resp.
  task automatic test_reset_mid();
    @(negedge clk);
    pmem_resp = 1'b0; d_read = 1'b1; d_address = 32'h180;
    @(negedge clk);
    #1;
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL mid_strobe: got %b want 1", pmem_read); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_read = 1'b0;
    #1;
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL mid_strobe_drop: got r/w=%b want 00", {pmem_read, pmem_write}); end
    pmem_resp = 1'b1;
    #1;
    checks++; if ({d_resp, i_resp} !== 2'b00) begin errors++; $display("FAIL mid_stale_resp: got d/i=%b want 00", {d_resp, i_resp}); end
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    checks++; if ({pmem_read, pmem_write, d_resp} !== 3'b000) begin errors++; $display("FAIL mid_idle: got r/w/d=%b want 000", {pmem_read, pmem_write, d_resp}); end
  endtask

  // Read and write together: downstream sees a write only.
  task automatic test_read_write_both();
    @(negedge clk);
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h300; d_wdata = 32'h1234_5678; d_byte_enable = 4'hF;
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++; if ({pmem_write, pmem_read} !== 2'b10) begin errors++; $display("FAIL rw_both_strobes: got w/r=%b want 10", {pmem_write, pmem_read}); end
    checks++; if (pmem_address !== 32'h300) begin errors++; $display("FAIL rw_both_addr: got %h want 00000300", pmem_address); end
    checks++; if (d_resp !== 1'b1) begin errors++; $display("FAIL rw_both_resp: got %b want 1", d_resp); end
    @(negedge clk);
    pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    #1;
    checks++; if ({pmem_write, pmem_read} !== 2'b00) begin errors++; $display("FAIL rw_both_clear: got w/r=%b want 00", {pmem_write, pmem_read}); end
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_tie_after_reset();
    test_write();
    test_alternate();
    test_reset_mid();
    test_read_write_both();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
